calc_op_ctrl: RTL

- Downstream of the keypad entry stage (keypad scanner, digit shift register, BCD to sign-magnitude, two's-complement conversion).
- Consumes the keypad key strobe, the key code and the 8-bit two's-complement entry value.
- Sequences operand A, operator, operand B and equals, then computes A+B or A-B in 8-bit two's complement with overflow detection.
- Drives the display-select and entry-clear controls back to the top level.

---
 rtl/calc_op_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/calc_op_ctrl.sv
// Operator/sequence controller for a two-operand keypad calculator.
// Synchronises the key strobe, lets the entry path settle, then drives an A/op/B/= FSM.
module calc_op_ctrl #(
    parameter int SETTLE = 2,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         key_valid,
    input  logic [3:0]   key_value,
    input  logic [W-1:0] entry,
    output logic         entry_clr,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         show_result,
    output logic         op_sub,
    output logic [1:0]   state
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_t;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic          r_sync1, r_sync2, r_sync_d;
    logic          r_pending;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_key;
    state_t        r_state, w_state_n;
    logic [W-1:0]  r_entry_q, w_entry_q_n;
    logic [W-1:0]  r_opa, w_opa_n;
    logic [W-1:0]  r_result, w_result_n;
    logic          r_overflow, w_overflow_n;
    logic          r_op_sub, w_op_sub_n;
    logic          r_entry_clr, w_entry_clr_n;
    logic          w_event, w_act;
    logic [W-1:0]  w_sum;
    logic          w_sum_ovf;

    assign w_event = r_sync2 & ~r_sync_d;
    assign w_act   = r_pending && (r_cnt == '0);

    // Key capture: the counter runs SETTLE-1..0 so the key is acted on SETTLE cycles after capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_sync_d  <= 1'b0;
            r_pending <= 1'b0;
            r_cnt     <= '0;
            r_key     <= '0;
        end else begin
            r_sync1  <= key_valid;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            if (w_event && !r_pending) begin
                r_pending <= 1'b1;
                r_key     <= key_value;
                r_cnt     <= CW'(SETTLE - 1);
            end else if (r_pending) begin
                if (r_cnt == '0) r_pending <= 1'b0;
                else             r_cnt     <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_sum     = r_op_sub ? (r_opa - r_entry_q) : (r_opa + r_entry_q);
        w_sum_ovf = r_op_sub ? ((r_opa[W-1] != r_entry_q[W-1]) && (w_sum[W-1] != r_opa[W-1]))
                             : ((r_opa[W-1] == r_entry_q[W-1]) && (w_sum[W-1] != r_opa[W-1]));
    end

    always_comb begin
        // NOTE: every next-value gets a hold default first so no path can infer a latch.
        w_state_n     = r_state;
        w_entry_q_n   = r_entry_q;
        w_opa_n       = r_opa;
        w_result_n    = r_result;
        w_overflow_n  = r_overflow;
        w_op_sub_n    = r_op_sub;
        w_entry_clr_n = 1'b0;
        if (r_state != S_A && r_state != S_B && r_state != S_RES) begin
            w_state_n = S_A;
        end else if (w_act) begin
            case (r_key)
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
                    if (r_state == S_RES) begin
                        w_entry_clr_n = 1'b1;
                        w_entry_q_n   = '0;
                        w_overflow_n  = 1'b0;
                        w_state_n     = S_A;
                    end else begin
                        w_entry_q_n = entry;
                    end
                end
                4'hA, 4'hB: begin
                    w_op_sub_n = (r_key == 4'hB);
                    if (r_state != S_B) begin
                        // From S_RES the previous result becomes operand A (chaining).
                        w_opa_n       = (r_state == S_RES) ? r_result : r_entry_q;
                        w_entry_q_n   = '0;
                        w_entry_clr_n = 1'b1;
                        w_overflow_n  = (r_state == S_RES) ? 1'b0 : r_overflow;
                        w_state_n     = S_B;
                    end
                end
                4'hC: begin
                    w_entry_q_n   = '0;
                    w_opa_n       = '0;
                    w_result_n    = '0;
                    w_overflow_n  = 1'b0;
                    w_op_sub_n    = 1'b0;
                    w_entry_clr_n = 1'b1;
                    w_state_n     = S_A;
                end
                4'hF: begin
                    if (r_state == S_B) begin
                        w_result_n    = w_sum;
                        w_overflow_n  = w_sum_ovf;
                        w_entry_clr_n = 1'b1;
                        w_state_n     = S_RES;
                    end else if (r_state == S_A) begin
                        w_result_n    = r_entry_q;
                        w_overflow_n  = 1'b0;
                        w_entry_clr_n = 1'b1;
                        w_state_n     = S_RES;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_A;
            r_entry_q   <= '0;
            r_opa       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_op_sub    <= 1'b0;
            r_entry_clr <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_entry_q   <= w_entry_q_n;
            r_opa       <= w_opa_n;
            r_result    <= w_result_n;
            r_overflow  <= w_overflow_n;
            r_op_sub    <= w_op_sub_n;
            r_entry_clr <= w_entry_clr_n;
        end
    end

    assign entry_clr   = r_entry_clr;
    assign result      = r_result;
    assign overflow    = r_overflow;
    assign op_sub      = r_op_sub;
    assign state       = r_state;
    assign show_result = (r_state == S_RES);

endmodule
